// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared types and constants for the ARM32 issue/operand-fetch stage.
//   reg_addr_t      : 4-bit architectural register index
//   PC_REG          : index of the program counter (R15)
//   PC_READ_OFFSET  : value added to the PC when R15 is read as an operand
//   USE_*           : bit positions inside the source-used mask
// -----------------------------------------------------------------------------
package cpu_pkg;

  typedef logic [3:0] reg_addr_t;

  localparam reg_addr_t   PC_REG         = 4'd15;
  localparam logic [31:0] PC_READ_OFFSET = 32'd8;
  localparam int          NUM_REGS       = 16;
  localparam int          NUM_SRC        = 4;

  localparam int USE_A     = 0;
  localparam int USE_B     = 1;
  localparam int USE_SHIFT = 2;
  localparam int USE_STR   = 3;

endpackage

// File: rtl/operand_bypass.sv
// -----------------------------------------------------------------------------
// operand_bypass
// Combinational resolver for one source operand.
// Ports:
//   i_addr            source register index
//   i_rf_data         value read from the register file for i_addr
//   i_w_en1..3        write-port enables (same nets as the register file)
//   i_w_addr1..3      write-port addresses
//   i_w_data1..3      write-port data
//   i_pc              PC of the instruction being issued
//   o_value           resolved operand value
// -----------------------------------------------------------------------------
module operand_bypass
  import cpu_pkg::*;
(
  input  reg_addr_t   i_addr,
  input  logic [31:0] i_rf_data,
  input  logic        i_w_en1,
  input  reg_addr_t   i_w_addr1,
  input  logic [31:0] i_w_data1,
  input  logic        i_w_en2,
  input  reg_addr_t   i_w_addr2,
  input  logic [31:0] i_w_data2,
  input  logic        i_w_en3,
  input  reg_addr_t   i_w_addr3,
  input  logic [31:0] i_w_data3,
  input  logic [31:0] i_pc,
  output logic [31:0] o_value
);

  // Later assignments override earlier ones, so port 3 beats port 2 beats
  // port 1, the same last-write-wins order the register file uses. R15 is
  // never written through these ports from the operand's point of view.
  always_comb begin
    o_value = i_rf_data;
    if (i_w_en1 && (i_w_addr1 == i_addr)) o_value = i_w_data1;
    if (i_w_en2 && (i_w_addr2 == i_addr)) o_value = i_w_data2;
    if (i_w_en3 && (i_w_addr3 == i_addr)) o_value = i_w_data3;
    if (i_addr == PC_REG)                 o_value = i_pc + PC_READ_OFFSET;
  end

endmodule

// File: rtl/operand_fetch.sv
// -----------------------------------------------------------------------------
// operand_fetch
// Issue stage in front of the register file. Drives the four read addresses,
// bypasses same-cycle register-file writes, tracks pending writers per
// register and stalls on RAW hazards or a saturated pending counter. Issued
// instructions land in a valid/ready output register feeding execute.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid / in_ready             decode handshake
//   in_A/B/shift/str_addr, in_use   source registers and used mask
//   in_dest_addr, in_dest_en        destination register
//   in_is_load, in_pc               carried-through instruction info
//   A/B/shift/str_addr (out)        register-file read addresses
//   A/B/shift/str_data (in)         register-file read data
//   w_en1..3, w_addr1..3, w_data1..3 register-file write ports
//   kill_en, kill_addr              one squashed in-flight writer
//   flush                           discard output register and input
//   out_valid / out_ready           execute handshake
//   out_A/B/shift/str, out_dest_*, out_is_load, out_pc   issued instruction
//   sb_err                          sticky pending-counter underflow flag
// -----------------------------------------------------------------------------
module operand_fetch
  import cpu_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  reg_addr_t   in_A_addr,
  input  reg_addr_t   in_B_addr,
  input  reg_addr_t   in_shift_addr,
  input  reg_addr_t   in_str_addr,
  input  logic [3:0]  in_use,
  input  reg_addr_t   in_dest_addr,
  input  logic        in_dest_en,
  input  logic        in_is_load,
  input  logic [31:0] in_pc,
  output reg_addr_t   A_addr,
  output reg_addr_t   B_addr,
  output reg_addr_t   shift_addr,
  output reg_addr_t   str_addr,
  input  logic [31:0] A_data,
  input  logic [31:0] B_data,
  input  logic [31:0] shift_data,
  input  logic [31:0] str_data,
  input  logic [31:0] w_data1,
  input  logic [31:0] w_data2,
  input  logic [31:0] w_data3,
  input  reg_addr_t   w_addr1,
  input  reg_addr_t   w_addr2,
  input  reg_addr_t   w_addr3,
  input  logic        w_en1,
  input  logic        w_en2,
  input  logic        w_en3,
  input  logic        kill_en,
  input  reg_addr_t   kill_addr,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_A,
  output logic [31:0] out_B,
  output logic [31:0] out_shift,
  output logic [31:0] out_str,
  output reg_addr_t   out_dest_addr,
  output logic        out_dest_en,
  output logic        out_is_load,
  output logic [31:0] out_pc,
  output logic        sb_err
);

  localparam int SW = CNT_W + 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // ---------------------------------------------------------------------------
  // Source operands
  // ---------------------------------------------------------------------------
  reg_addr_t   w_src_addr [NUM_SRC];
  logic [31:0] w_rf_data  [NUM_SRC];
  logic [31:0] w_src_val  [NUM_SRC];
  logic        w_src_haz  [NUM_SRC];

  assign A_addr     = in_A_addr;
  assign B_addr     = in_B_addr;
  assign shift_addr = in_shift_addr;
  assign str_addr   = in_str_addr;

  assign w_src_addr[USE_A]     = in_A_addr;
  assign w_src_addr[USE_B]     = in_B_addr;
  assign w_src_addr[USE_SHIFT] = in_shift_addr;
  assign w_src_addr[USE_STR]   = in_str_addr;

  assign w_rf_data[USE_A]      = A_data;
  assign w_rf_data[USE_B]      = B_data;
  assign w_rf_data[USE_SHIFT]  = shift_data;
  assign w_rf_data[USE_STR]    = str_data;

  // ---------------------------------------------------------------------------
  // Pending-writer scoreboard
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] r_cnt      [NUM_REGS];
  logic [CNT_W-1:0] w_cnt_next [NUM_REGS];
  logic [2:0]       w_dec      [NUM_REGS];
  logic             w_inc      [NUM_REGS];
  logic [SW-1:0]    w_sum      [NUM_REGS];
  logic [SW-1:0]    w_left     [NUM_REGS];
  logic             w_pending  [NUM_REGS];
  logic             w_under    [NUM_REGS];
  logic             r_sb_err;
  logic             w_any_under;
  logic             w_hazard;
  logic             w_full;
  logic             w_stall;
  logic             w_fire;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (gi == int'(PC_REG)) begin : g_pc
        // The PC is never tracked: it can never stall or underflow.
        assign w_dec[gi]      = '0;
        assign w_inc[gi]      = 1'b0;
        assign w_sum[gi]      = '0;
        assign w_left[gi]     = '0;
        assign w_pending[gi]  = 1'b0;
        assign w_under[gi]    = 1'b0;
        assign w_cnt_next[gi] = '0;
      end else begin : g_gpr
        assign w_dec[gi] = 3'(w_en1 && (w_addr1 == 4'(gi)))
                         + 3'(w_en2 && (w_addr2 == 4'(gi)))
                         + 3'(w_en3 && (w_addr3 == 4'(gi)))
                         + 3'(kill_en && (kill_addr == 4'(gi)));
        assign w_inc[gi] = w_fire && in_dest_en && (in_dest_addr == 4'(gi));

        // Two extra bits: one for the +1 headroom, one as the sign bit.
        assign w_sum[gi]  = SW'(r_cnt[gi]) + SW'(w_inc[gi]) - SW'(w_dec[gi]);
        assign w_left[gi] = SW'(r_cnt[gi]) - SW'(w_dec[gi]);

        // Writers still outstanding once this cycle's writes are counted.
        assign w_pending[gi] = !w_left[gi][SW-1] && (w_left[gi] != '0);
        assign w_under[gi]   = w_sum[gi][SW-1];

        // Issue is blocked when the counter is saturated, so the sum never
        // exceeds CNT_MAX and truncation is safe.
        assign w_cnt_next[gi] = w_under[gi] ? '0 : w_sum[gi][CNT_W-1:0];
      end
    end

    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      operand_bypass u_bypass (
        .i_addr    (w_src_addr[gi]),
        .i_rf_data (w_rf_data[gi]),
        .i_w_en1   (w_en1),
        .i_w_addr1 (w_addr1),
        .i_w_data1 (w_data1),
        .i_w_en2   (w_en2),
        .i_w_addr2 (w_addr2),
        .i_w_data2 (w_data2),
        .i_w_en3   (w_en3),
        .i_w_addr3 (w_addr3),
        .i_w_data3 (w_data3),
        .i_pc      (in_pc),
        .o_value   (w_src_val[gi])
      );

      // R15 has no pending entry, so w_pending already masks it.
      assign w_src_haz[gi] = in_use[gi] && w_pending[w_src_addr[gi]];
    end
  endgenerate

  always_comb begin
    w_hazard    = 1'b0;
    w_any_under = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) w_hazard = w_hazard | w_src_haz[s];
    for (int r = 0; r < NUM_REGS; r++) w_any_under = w_any_under | w_under[r];
  end

  assign w_full   = in_dest_en && (r_cnt[in_dest_addr] == CNT_MAX);
  assign w_stall  = w_hazard || w_full;
  assign in_ready = !w_stall && (!out_valid || out_ready) && !flush;
  assign w_fire   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) r_cnt[r] <= '0;
      r_sb_err <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) r_cnt[r] <= w_cnt_next[r];
      r_sb_err <= r_sb_err | w_any_under;
    end
  end

  assign sb_err = r_sb_err;

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  logic        r_out_valid;
  logic [31:0] r_out_A;
  logic [31:0] r_out_B;
  logic [31:0] r_out_shift;
  logic [31:0] r_out_str;
  reg_addr_t   r_out_dest_addr;
  logic        r_out_dest_en;
  logic        r_out_is_load;
  logic [31:0] r_out_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid     <= 1'b0;
      r_out_A         <= '0;
      r_out_B         <= '0;
      r_out_shift     <= '0;
      r_out_str       <= '0;
      r_out_dest_addr <= '0;
      r_out_dest_en   <= 1'b0;
      r_out_is_load   <= 1'b0;
      r_out_pc        <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_fire) begin
      r_out_valid     <= 1'b1;
      r_out_A         <= w_src_val[USE_A];
      r_out_B         <= w_src_val[USE_B];
      r_out_shift     <= w_src_val[USE_SHIFT];
      r_out_str       <= w_src_val[USE_STR];
      r_out_dest_addr <= in_dest_addr;
      r_out_dest_en   <= in_dest_en;
      r_out_is_load   <= in_is_load;
      r_out_pc        <= in_pc;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid     = r_out_valid;
  assign out_A         = r_out_A;
  assign out_B         = r_out_B;
  assign out_shift     = r_out_shift;
  assign out_str       = r_out_str;
  assign out_dest_addr = r_out_dest_addr;
  assign out_dest_en   = r_out_dest_en;
  assign out_is_load   = r_out_is_load;
  assign out_pc        = r_out_pc;

endmodule

// File: tb/tb_operand_fetch.sv
// -----------------------------------------------------------------------------
// tb_operand_fetch
// Self-checking bench for operand_fetch. A small register-file model feeds the
// read data; issued instructions are recorded in an expected-output queue and
// compared when execute accepts them.
// -----------------------------------------------------------------------------
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [3:0]  in_A_addr, in_B_addr, in_shift_addr, in_str_addr;
  logic [3:0]  in_use, in_dest_addr;
  logic        in_dest_en, in_is_load;
  logic [31:0] in_pc;
  logic [3:0]  A_addr, B_addr, shift_addr, str_addr;
  logic [31:0] A_data, B_data, shift_data, str_data;
  logic [31:0] w_data1, w_data2, w_data3;
  logic [3:0]  w_addr1, w_addr2, w_addr3;
  logic        w_en1, w_en2, w_en3;
  logic        kill_en;
  logic [3:0]  kill_addr;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_A, out_B, out_shift, out_str, out_pc;
  logic [3:0]  out_dest_addr;
  logic        out_dest_en, out_is_load;
  logic        sb_err;

  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 clk = ~clk;

  operand_fetch #(.CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_A_addr(in_A_addr), .in_B_addr(in_B_addr),
    .in_shift_addr(in_shift_addr), .in_str_addr(in_str_addr),
    .in_use(in_use), .in_dest_addr(in_dest_addr), .in_dest_en(in_dest_en),
    .in_is_load(in_is_load), .in_pc(in_pc),
    .A_addr(A_addr), .B_addr(B_addr), .shift_addr(shift_addr), .str_addr(str_addr),
    .A_data(A_data), .B_data(B_data), .shift_data(shift_data), .str_data(str_data),
    .w_data1(w_data1), .w_data2(w_data2), .w_data3(w_data3),
    .w_addr1(w_addr1), .w_addr2(w_addr2), .w_addr3(w_addr3),
    .w_en1(w_en1), .w_en2(w_en2), .w_en3(w_en3),
    .kill_en(kill_en), .kill_addr(kill_addr), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_A(out_A), .out_B(out_B), .out_shift(out_shift), .out_str(out_str),
    .out_dest_addr(out_dest_addr), .out_dest_en(out_dest_en),
    .out_is_load(out_is_load), .out_pc(out_pc), .sb_err(sb_err)
  );

  // Register-file model: reset contents are R[i] = 0x11*i, last write wins.
  logic [31:0] rf [16];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) rf[i] <= 32'h11 * i;
    end else begin
      if (w_en1) rf[w_addr1] <= w_data1;
      if (w_en2) rf[w_addr2] <= w_data2;
      if (w_en3) rf[w_addr3] <= w_data3;
    end
  end
  assign A_data     = rf[A_addr];
  assign B_data     = rf[B_addr];
  assign shift_data = rf[shift_addr];
  assign str_data   = rf[str_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] a, b, sh, st, pc;
    logic [3:0]  dest;
    logic        dest_en, is_load;
  } exp_t;
  exp_t exp_q[$];

  function automatic logic [31:0] model_res(input logic [3:0] ad);
    logic [31:0] v;
    v = rf[ad];
    if (w_en1 && w_addr1 == ad) v = w_data1;
    if (w_en2 && w_addr2 == ad) v = w_data2;
    if (w_en3 && w_addr3 == ad) v = w_data3;
    if (ad == 4'd15) v = in_pc + 32'd8;
    return v;
  endfunction

  task automatic cmp_out(input exp_t e, input string pfx);
    chk({pfx, "_A"},    out_A, e.a);
    chk({pfx, "_B"},    out_B, e.b);
    chk({pfx, "_sh"},   out_shift, e.sh);
    chk({pfx, "_st"},   out_str, e.st);
    chk({pfx, "_pc"},   out_pc, e.pc);
    chk({pfx, "_dest"}, {28'd0, out_dest_addr}, {28'd0, e.dest});
    chk({pfx, "_den"},  {31'd0, out_dest_en}, {31'd0, e.dest_en});
    chk({pfx, "_ld"},   {31'd0, out_is_load}, {31'd0, e.is_load});
  endtask

  // Scoreboard: retire/hold-check the output register, then record any fire.
  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      if (flush) begin
        if (out_valid && exp_q.size() > 0) void'(exp_q.pop_front());
      end else if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_out", 32'd1, 32'd0);
        end else if (out_ready) begin
          e = exp_q.pop_front();
          cmp_out(e, "out");
          $display("txn pc=0x%08h A=0x%08h B=0x%08h dest=%0d/%0b ld=%0b",
                   out_pc, out_A, out_B, out_dest_addr, out_dest_en, out_is_load);
        end else begin
          cmp_out(exp_q[0], "hold");
        end
      end
      if (in_valid && in_ready) begin
        e.a = model_res(in_A_addr);     e.b = model_res(in_B_addr);
        e.sh = model_res(in_shift_addr); e.st = model_res(in_str_addr);
        e.pc = in_pc; e.dest = in_dest_addr;
        e.dest_en = in_dest_en; e.is_load = in_is_load;
        exp_q.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] use_m, input logic [3:0] dest,
                           input logic den, input logic ld, input logic [31:0] pc);
    in_A_addr = a; in_B_addr = b; in_shift_addr = 4'd0; in_str_addr = 4'd0;
    in_use = use_m; in_dest_addr = dest; in_dest_en = den;
    in_is_load = ld; in_pc = pc; in_valid = 1'b1;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_use = 4'd0; in_dest_en = 1'b0; in_is_load = 1'b0;
  endtask

  task automatic clr_w();
    w_en1 = 1'b0; w_en2 = 1'b0; w_en3 = 1'b0; kill_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_A_addr = '0; in_B_addr = '0; in_shift_addr = '0; in_str_addr = '0;
    in_dest_addr = '0; in_pc = '0; idle();
    w_data1 = '0; w_data2 = '0; w_data3 = '0;
    w_addr1 = '0; w_addr2 = '0; w_addr3 = '0; kill_addr = '0;
    clr_w();

    // Reset state
    step(); step();
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_A", out_A, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_sb_err", {31'd0, sb_err}, 32'd0);
    rst_n = 1'b1;
    step();

    // Read addresses are combinational copies
    in_A_addr = 4'd9; in_str_addr = 4'd12;
    #1;
    chk("addr_A_copy", {28'd0, A_addr}, 32'd9);
    chk("addr_str_copy", {28'd0, str_addr}, 32'd12);

    // Forwarding priority: three pending writers of R3 retired together
    for (int k = 0; k < 3; k++) begin
      set_instr(4'd0, 4'd0, 4'b0000, 4'd3, 1'b1, 1'b0, 32'h10 + 32'(4 * k));
      @(negedge clk); chk("fwd_wr_rdy", {31'd0, in_ready}, 32'd1);
      step();
    end
    w_en1 = 1'b1; w_addr1 = 4'd3; w_data1 = 32'hA;
    w_en2 = 1'b1; w_addr2 = 4'd3; w_data2 = 32'hB;
    w_en3 = 1'b1; w_addr3 = 4'd3; w_data3 = 32'hC;
    set_instr(4'd1, 4'd3, 4'b0011, 4'd0, 1'b0, 1'b0, 32'h200);
    @(negedge clk); chk("fwd_rdy", {31'd0, in_ready}, 32'd1);
    step(); clr_w(); idle();
    @(negedge clk);
    chk("fwd_out_B", out_B, 32'hC);
    chk("fwd_out_A", out_A, 32'h11);

    // PC read
    step();
    set_instr(4'd15, 4'd0, 4'b0001, 4'd0, 1'b0, 1'b0, 32'h100);
    @(negedge clk); chk("pc_rdy", {31'd0, in_ready}, 32'd1);
    step(); idle();
    @(negedge clk); chk("pc_out_A", out_A, 32'h108);

    // RAW stall on a load result
    step();
    set_instr(4'd0, 4'd0, 4'b0000, 4'd2, 1'b1, 1'b1, 32'h120);
    @(negedge clk); chk("raw_ldr_rdy", {31'd0, in_ready}, 32'd1);
    step();
    set_instr(4'd2, 4'd0, 4'b0001, 4'd0, 1'b0, 1'b0, 32'h124);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); chk("raw_stall", {31'd0, in_ready}, 32'd0);
      step();
    end
    w_en3 = 1'b1; w_addr3 = 4'd2; w_data3 = 32'h55;
    @(negedge clk); chk("raw_release", {31'd0, in_ready}, 32'd1);
    step(); clr_w(); idle();
    in_A_addr = 4'd2; in_use = 4'b0001;
    @(negedge clk);
    chk("raw_out_A", out_A, 32'h55);
    chk("raw_cnt_clear", {31'd0, in_ready}, 32'd1);

    // Scoreboard full at three writers of R4
    step();
    for (int k = 0; k < 3; k++) begin
      set_instr(4'd0, 4'd0, 4'b0000, 4'd4, 1'b1, 1'b0, 32'h140 + 32'(4 * k));
      @(negedge clk); chk("full_wr_rdy", {31'd0, in_ready}, 32'd1);
      step();
    end
    set_instr(4'd0, 4'd0, 4'b0000, 4'd4, 1'b1, 1'b0, 32'h150);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); chk("full_stall", {31'd0, in_ready}, 32'd0);
      step();
    end
    w_en1 = 1'b1; w_addr1 = 4'd4; w_data1 = 32'h44;
    @(negedge clk); chk("full_write_cycle", {31'd0, in_ready}, 32'd0);
    step(); clr_w();
    @(negedge clk); chk("full_release", {31'd0, in_ready}, 32'd1);
    step(); idle();
    w_en1 = 1'b1; w_addr1 = 4'd4; w_data1 = 32'h45;
    w_en2 = 1'b1; w_addr2 = 4'd4; w_data2 = 32'h46;
    w_en3 = 1'b1; w_addr3 = 4'd4; w_data3 = 32'h47;
    step(); clr_w();
    in_A_addr = 4'd4; in_use = 4'b0001;
    @(negedge clk); chk("full_drained", {31'd0, in_ready}, 32'd1);
    chk("full_no_err", {31'd0, sb_err}, 32'd0);

    // Issue and write of the same register in one cycle: net zero
    step();
    set_instr(4'd0, 4'd0, 4'b0000, 4'd8, 1'b1, 1'b0, 32'h160);
    @(negedge clk); step();
    set_instr(4'd0, 4'd0, 4'b0000, 4'd8, 1'b1, 1'b0, 32'h164);
    w_en2 = 1'b1; w_addr2 = 4'd8; w_data2 = 32'h88;
    @(negedge clk); chk("net0_rdy", {31'd0, in_ready}, 32'd1);
    step(); clr_w();
    set_instr(4'd8, 4'd0, 4'b0001, 4'd0, 1'b0, 1'b0, 32'h168);
    @(negedge clk); chk("net0_still_pending", {31'd0, in_ready}, 32'd0);
    step();
    w_en1 = 1'b1; w_addr1 = 4'd8; w_data1 = 32'h89;
    @(negedge clk); chk("net0_release", {31'd0, in_ready}, 32'd1);
    step(); clr_w(); idle();
    @(negedge clk); chk("net0_out_A", out_A, 32'h89);
    step(); step();

    // Backpressure hold, then flush
    out_ready = 1'b0;
    set_instr(4'd1, 4'd0, 4'b0001, 4'd0, 1'b0, 1'b0, 32'h300);
    @(negedge clk); chk("bp_first_rdy", {31'd0, in_ready}, 32'd1);
    step();
    set_instr(4'd0, 4'd0, 4'b0000, 4'd7, 1'b1, 1'b0, 32'h304);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_hold_pc", out_pc, 32'h300);
      chk("bp_hold_A", out_A, 32'h11);
      chk("bp_blocked", {31'd0, in_ready}, 32'd0);
      step();
    end
    flush = 1'b1;
    @(negedge clk); chk("flush_rdy", {31'd0, in_ready}, 32'd0);
    step(); flush = 1'b0; idle(); out_ready = 1'b1;
    in_A_addr = 4'd7; in_use = 4'b0001;
    @(negedge clk);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_no_inc", {31'd0, in_ready}, 32'd1);

    // Kill and underflow
    step();
    set_instr(4'd0, 4'd0, 4'b0000, 4'd5, 1'b1, 1'b0, 32'h320);
    @(negedge clk); step(); idle();
    kill_en = 1'b1; kill_addr = 4'd5;
    step(); clr_w();
    in_A_addr = 4'd5; in_use = 4'b0001;
    @(negedge clk);
    chk("kill_cnt_zero", {31'd0, in_ready}, 32'd1);
    chk("kill_no_err", {31'd0, sb_err}, 32'd0);
    step();
    kill_en = 1'b1; kill_addr = 4'd5;
    step(); clr_w();
    @(negedge clk);
    chk("underflow_err", {31'd0, sb_err}, 32'd1);
    chk("underflow_cnt_zero", {31'd0, in_ready}, 32'd1);
    step();
    @(negedge clk);
    chk("sb_err_sticky", {31'd0, sb_err}, 32'd1);
    chk("sb_queue_empty", exp_q.size(), 32'd0);

    // Asynchronous reset clears the sticky flag immediately
    rst_n = 1'b0;
    #1;
    chk("rst_clears_err", {31'd0, sb_err}, 32'd0);
    chk("rst_clears_valid", {31'd0, out_valid}, 32'd0);
    exp_q.delete();
    step();
    rst_n = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
